// File: rtl/mesh_router_xy.sv
// 5-port XY wormhole router: per-input FIFOs with on/off flow control, per-output
// round-robin allocation with packet locking, and a registered output stage.
module mesh_router_xy #(
  parameter int unsigned    DATA_W    = 32,
  parameter int unsigned    BUF_DEPTH = 8,
  parameter int unsigned    OFF_THR   = 5,
  parameter int unsigned    ON_THR    = 2,
  parameter int unsigned    X_W       = 3,
  parameter int unsigned    Y_W       = 3,
  parameter logic [X_W-1:0] MY_X      = '0,
  parameter logic [Y_W-1:0] MY_Y      = '0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5*(DATA_W+2)-1:0] i_flit,
  input  logic [4:0]              i_valid,
  output logic [4:0]              o_on_off,
  input  logic [4:0]              i_on_off,
  output logic [5*(DATA_W+2)-1:0] o_flit,
  output logic [4:0]              o_valid,
  output logic [4:0]              o_err
);

  localparam int          NP     = 5;
  localparam int unsigned FLIT_W = DATA_W + 2;
  localparam int unsigned PTR_W  = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  localparam logic [2:0] PortL = 3'd0;
  localparam logic [2:0] PortN = 3'd1;
  localparam logic [2:0] PortE = 3'd2;
  localparam logic [2:0] PortS = 3'd3;
  localparam logic [2:0] PortW = 3'd4;

  // Type field: MSB set means a packet start (HEAD or HEAD_TAIL).
  localparam logic [1:0] TyTail = 2'b01;
  localparam logic [1:0] TyHead = 2'b10;

  typedef enum logic {OutFree, OutLocked} out_state_e;

  logic [FLIT_W-1:0] mem_q [NP][BUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NP];
  logic [PTR_W-1:0]  rd_ptr_q [NP];
  logic [CNT_W-1:0]  count_q [NP];
  logic [CNT_W-1:0]  count_d [NP];
  logic [NP-1:0]     on_off_q, on_off_d;
  logic [NP-1:0]     err_q, err_d;

  logic [FLIT_W-1:0] head [NP];
  logic [1:0]        head_type [NP];
  logic [2:0]        head_route [NP];
  logic [NP-1:0]     not_empty, full, push, owns, cand, orphan, pop;

  out_state_e        state_q [NP];
  out_state_e        state_d [NP];
  logic [2:0]        owner_q [NP];
  logic [2:0]        owner_d [NP];
  logic [2:0]        rr_q [NP];
  logic [2:0]        rr_d [NP];
  logic [NP-1:0]     fwd;
  logic [FLIT_W-1:0] fwd_flit [NP];
  logic [FLIT_W-1:0] o_flit_q [NP];
  logic [NP-1:0]     o_valid_q;

  function automatic logic [2:0] xy_route(input logic [X_W+Y_W-1:0] coord);
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    dx = coord[X_W+Y_W-1:Y_W];
    dy = coord[Y_W-1:0];
    if (dx > MY_X) return PortE;
    if (dx < MY_X) return PortW;
    if (dy > MY_Y) return PortN;
    if (dy < MY_Y) return PortS;
    return PortL;
  endfunction

  // Per-input FIFO head status and routing.
  always_comb begin
    not_empty = '0;
    full      = '0;
    push      = '0;
    owns      = '0;
    cand      = '0;
    orphan    = '0;
    for (int p = 0; p < NP; p++) begin
      head[p]       = mem_q[p][rd_ptr_q[p]];
      head_type[p]  = head[p][FLIT_W-1 -: 2];
      head_route[p] = xy_route(head[p][X_W+Y_W-1:0]);
      not_empty[p]  = count_q[p] != '0;
      full[p]       = count_q[p] == CNT_W'(BUF_DEPTH);
      push[p]       = i_valid[p] & ~full[p];
      for (int o = 0; o < NP; o++) begin
        if (state_q[o] == OutLocked && owner_q[o] == 3'(p)) owns[p] = 1'b1;
      end
      // An input that owns an output feeds only that output, so it never competes.
      cand[p]   = not_empty[p] & ~owns[p] & head_type[p][1];
      orphan[p] = not_empty[p] & ~owns[p] & ~head_type[p][1];
    end
  end

  // Switch allocation and lock tracking per output.
  always_comb begin
    logic found;
    int   src;
    found = 1'b0;
    src   = 0;
    fwd   = '0;
    pop   = orphan;
    for (int o = 0; o < NP; o++) begin
      state_d[o]  = state_q[o];
      owner_d[o]  = owner_q[o];
      rr_d[o]     = rr_q[o];
      fwd_flit[o] = '0;
    end
    for (int o = 0; o < NP; o++) begin
      if (i_on_off[o]) begin
        if (state_q[o] == OutLocked) begin
          for (int i = 0; i < NP; i++) begin
            if (owner_q[o] == 3'(i) && not_empty[i]) begin
              fwd[o]      = 1'b1;
              fwd_flit[o] = head[i];
              pop[i]      = 1'b1;
              if (head_type[i] == TyTail) state_d[o] = OutFree;
            end
          end
        end else begin
          found = 1'b0;
          for (int k = 1; k <= NP; k++) begin
            src = (int'(rr_q[o]) + k) % NP;
            if (!found && cand[src] && head_route[src] == 3'(o)) begin
              found       = 1'b1;
              fwd[o]      = 1'b1;
              fwd_flit[o] = head[src];
              pop[src]    = 1'b1;
              rr_d[o]     = 3'(src);
              if (head_type[src] == TyHead) begin
                state_d[o] = OutLocked;
                owner_d[o] = 3'(src);
              end
            end
          end
        end
      end
    end
  end

  // Occupancy, flow control and sticky errors; fullness is judged on the pre-edge count.
  always_comb begin
    err_d    = err_q | (i_valid & full) | orphan;
    on_off_d = on_off_q;
    for (int p = 0; p < NP; p++) begin
      count_d[p] = count_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      if (count_d[p] >= CNT_W'(OFF_THR)) begin
        on_off_d[p] = 1'b0;
      end else if (count_d[p] <= CNT_W'(ON_THR)) begin
        on_off_d[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push[p]) mem_q[p][wr_ptr_q[p]] <= i_flit[p*FLIT_W +: FLIT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int p = 0; p < NP; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        count_q[p]  <= '0;
        state_q[p]  <= OutFree;
        owner_q[p]  <= '0;
        rr_q[p]     <= 3'd4;
        o_flit_q[p] <= '0;
      end
      on_off_q  <= '1;
      err_q     <= '0;
      o_valid_q <= '0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (push[p]) wr_ptr_q[p] <= wr_ptr_q[p] + PTR_W'(1);
        if (pop[p])  rd_ptr_q[p] <= rd_ptr_q[p] + PTR_W'(1);
        count_q[p] <= count_d[p];
        state_q[p] <= state_d[p];
        owner_q[p] <= owner_d[p];
        rr_q[p]    <= rr_d[p];
        if (fwd[p]) o_flit_q[p] <= fwd_flit[p];
      end
      on_off_q  <= on_off_d;
      err_q     <= err_d;
      o_valid_q <= fwd;
    end
  end

  always_comb begin
    o_flit = '0;
    for (int o = 0; o < NP; o++) o_flit[o*FLIT_W +: FLIT_W] = o_flit_q[o];
  end

  assign o_valid  = o_valid_q;
  assign o_on_off = on_off_q;
  assign o_err    = err_q;

endmodule
